// File: rtl/spi_rr_scheduler.sv
// Round-robin scheduler sharing one SPI master byte engine among NREQ requesters.
// A request is launched with m_start, tracked through the chip-select low/high
// handshake, and answered with a one-cycle done pulse plus the received byte.
// A per-phase watchdog aborts transfers whose handshake stalls.
module spi_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        rsp_data,
    output logic                 timeout_err,
    output logic                 busy,
    output logic                 m_start,
    output logic [DW-1:0]        m_data_in,
    input  logic                 m_cs,
    input  logic [DW-1:0]        m_data_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic [IW-1:0]   last, last_nx;
    logic [IW-1:0]   win, cand;
    logic            found;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            wd_hit;
    logic            xfer_end, wd_abort;
    logic [NREQ-1:0] gnt_nx, done_nx;
    logic [DW-1:0]   rsp_nx, m_data_nx;
    logic            terr_nx, m_start_nx;

    // The counter value reached on the next increment equals TIMEOUT.
    assign wd_hit = (cnt == CW'(TIMEOUT - 1));
    assign busy   = (state != IDLE);

    // Pick the first pending requester after the last one served, wrapping around.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        last_nx    = last;
        cnt_nx     = cnt;
        gnt_nx     = gnt;
        done_nx    = '0;
        terr_nx    = 1'b0;
        rsp_nx     = rsp_data;
        m_start_nx = m_start;
        m_data_nx  = m_data_in;
        xfer_end   = 1'b0;
        wd_abort   = 1'b0;

        case (state)
            // DONE arbitrates exactly like IDLE so a new grant can follow the done pulse directly.
            IDLE, DONE: begin
                state_nx = IDLE;
                if (found && m_cs) begin
                    state_nx    = LAUNCH;
                    idx_nx      = win;
                    gnt_nx      = '0;
                    gnt_nx[win] = 1'b1;
                    m_data_nx   = req_data[int'(win)*DW +: DW];
                    m_start_nx  = 1'b1;
                    cnt_nx      = '0;
                end
            end
            LAUNCH: begin
                if (!m_cs) begin
                    state_nx   = WAIT_HI;
                    m_start_nx = 1'b0;
                    cnt_nx     = '0;
                end else if (wd_hit) begin
                    xfer_end = 1'b1;
                    wd_abort = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_HI: begin
                if (m_cs) begin
                    xfer_end = 1'b1;
                end else if (wd_hit) begin
                    xfer_end = 1'b1;
                    wd_abort = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (xfer_end) begin
            state_nx      = DONE;
            gnt_nx        = '0;
            done_nx[idx]  = 1'b1;
            last_nx       = idx;
            m_start_nx    = 1'b0;
            rsp_nx        = wd_abort ? '0 : m_data_out;
            terr_nx       = wd_abort;
        end
    end

    // State and registered outputs; reset aborts any transfer in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            last        <= IW'(NREQ - 1);
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            rsp_data    <= '0;
            timeout_err <= 1'b0;
            m_start     <= 1'b0;
            m_data_in   <= '0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            last        <= last_nx;
            cnt         <= cnt_nx;
            gnt         <= gnt_nx;
            done        <= done_nx;
            rsp_data    <= rsp_nx;
            timeout_err <= terr_nx;
            m_start     <= m_start_nx;
            m_data_in   <= m_data_nx;
        end
    end

endmodule
